// File: rtl/count_sched.sv
// count_sched: round-robin issue scheduler for the dual event counter.
// Each channel queues requests in a saturating pending counter; at most one
// increment per cycle is issued downstream as a registered En/Slt pair.
module count_sched #(
  parameter int CREDIT_W = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req0,
  input  logic                Req1,
  input  logic                Hold,
  input  logic                OvfClr,
  output logic                En,
  output logic                Slt,
  output logic [CREDIT_W-1:0] Pend0,
  output logic [CREDIT_W-1:0] Pend1,
  output logic                Ovf0,
  output logic                Ovf1,
  output logic                Idle
);

  logic [1:0]          req;
  logic [1:0]          grant;
  logic [1:0]          full;
  logic [1:0]          drop;
  logic [1:0]          nonzero;

  logic [CREDIT_W-1:0] pend_q [2];
  logic [CREDIT_W-1:0] pend_d [2];
  logic                ovf_q  [2];
  logic                ovf_d  [2];

  logic                en_q, en_d;
  logic                slt_q, slt_d;
  // Last-served channel; reset to 1 so channel 0 wins the first tie.
  logic                last_q, last_d;

  assign req = {Req1, Req0};

  // Per-channel queue bookkeeping: saturating count and sticky drop flag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign nonzero[gi] = |pend_q[gi];
    assign full[gi]    = &pend_q[gi];
    // A request is only dropped when the counter is full and the same edge
    // does not also drain one entry through a grant.
    assign drop[gi]    = req[gi] & ~grant[gi] & full[gi];
    assign pend_d[gi]  = (req[gi] & ~grant[gi] & ~full[gi]) ? pend_q[gi] + CREDIT_W'(1) :
                         (~req[gi] & grant[gi])             ? pend_q[gi] - CREDIT_W'(1) :
                                                              pend_q[gi];
    // Set beats clear when a drop coincides with OvfClr.
    assign ovf_d[gi]   = drop[gi] | (ovf_q[gi] & ~OvfClr);

    // Pending counter and overflow flag registers.
    always_ff @(posedge Clk) begin
      if (!Reset) begin
        pend_q[gi] <= '0;
        ovf_q[gi]  <= 1'b0;
      end else begin
        pend_q[gi] <= pend_d[gi];
        ovf_q[gi]  <= ovf_d[gi];
      end
    end
  end

  // Round-robin grant from registered counts, last pointer and live Hold.
  always_comb begin
    grant  = 2'b00;
    en_d   = 1'b0;
    slt_d  = slt_q;
    last_d = last_q;
    if (!Hold) begin
      if (nonzero[0] && (!nonzero[1] || last_q)) begin
        grant = 2'b01;
      end else if (nonzero[1]) begin
        grant = 2'b10;
      end
    end
    if (grant != 2'b00) begin
      en_d   = 1'b1;
      slt_d  = grant[1];
      last_d = grant[1];
    end
  end

  // Issue output and last-served pointer registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      en_q   <= 1'b0;
      slt_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      en_q   <= en_d;
      slt_q  <= slt_d;
      last_q <= last_d;
    end
  end

  assign En    = en_q;
  assign Slt   = slt_q;
  assign Pend0 = pend_q[0];
  assign Pend1 = pend_q[1];
  assign Ovf0  = ovf_q[0];
  assign Ovf1  = ovf_q[1];
  assign Idle  = (pend_q[0] == '0) && (pend_q[1] == '0) && !en_q;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: expected issue channels are queued as the
// stimulus creates them and checked whenever the DUT raises En.
module tb_count_sched;

  localparam int CW = 4;

  logic          Clk;
  logic          Reset;
  logic          Req0, Req1, Hold, OvfClr;
  logic          En, Slt, Ovf0, Ovf1, Idle;
  logic [CW-1:0] Pend0, Pend1;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  count_sched #(.CREDIT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .Hold(Hold),
    .OvfClr(OvfClr), .En(En), .Slt(Slt), .Pend0(Pend0), .Pend1(Pend1),
    .Ovf0(Ovf0), .Ovf1(Ovf1), .Idle(Idle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic ch);
    exp_q.push_back(ch);
  endtask

  // Scoreboard: every issue must match the oldest outstanding expectation.
  always @(posedge Clk) begin
    #1;
    if (En === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_issue: observed slt %0d expected no issue", Slt);
      end
      if (exp_q.size() != 0) begin
        logic e;
        e = exp_q.pop_front();
        chk("issue_slt", 32'(Slt), 32'(e));
        $display("issue slt=%0d expected=%0d t=%0t", Slt, e, $time);
      end
    end
  end

  initial begin
    Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1; Hold = 1'b0; OvfClr = 1'b0;

    // Reset held with requests active: nothing queues, nothing issues.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_en", 32'(En), 0);
      chk("rst_slt", 32'(Slt), 0);
      chk("rst_pend0", 32'(Pend0), 0);
      chk("rst_pend1", 32'(Pend1), 0);
      chk("rst_ovf", 32'({Ovf1, Ovf0}), 0);
      chk("rst_idle", 32'(Idle), 1);
    end
    Reset = 1'b1;
    push(1'b0); push(1'b1);
    tick();
    chk("rel_pend0", 32'(Pend0), 1);
    chk("rel_pend1", 32'(Pend1), 1);
    chk("rel_en", 32'(En), 0);
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    chk("rel_first_pend0", 32'(Pend0), 0);
    tick();
    tick();
    chk("rel_idle", 32'(Idle), 1);

    // Round-robin: 3 queued on ch0, 2 on ch1, then release Hold.
    Hold = 1'b1; Req0 = 1'b1; Req1 = 1'b1;
    tick(); tick();
    Req1 = 1'b0;
    tick();
    Req0 = 1'b0;
    chk("rr_pend0", 32'(Pend0), 3);
    chk("rr_pend1", 32'(Pend1), 2);
    chk("rr_hold_en", 32'(En), 0);
    push(1'b0); push(1'b1); push(1'b0); push(1'b1); push(1'b0);
    Hold = 1'b0;
    repeat (5) tick();
    chk("rr_last_en", 32'(En), 1);
    tick();
    chk("rr_done_en", 32'(En), 0);
    chk("rr_done_pend", 32'({Pend1, Pend0}), 0);

    // Single request: two edges from request to issue.
    Req0 = 1'b1;
    tick();
    Req0 = 1'b0;
    chk("single_pend0", 32'(Pend0), 1);
    chk("single_en0", 32'(En), 0);
    push(1'b0);
    tick();
    chk("single_en1", 32'(En), 1);
    chk("single_pend0_drained", 32'(Pend0), 0);
    chk("single_idle_busy", 32'(Idle), 0);
    tick();
    chk("single_idle", 32'(Idle), 1);

    // Saturation of channel 1 under Hold.
    Hold = 1'b1; Req1 = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) begin
        chk("sat15_pend1", 32'(Pend1), 15);
        chk("sat15_ovf1", 32'(Ovf1), 0);
      end
      if (i == 16) begin
        chk("sat16_pend1", 32'(Pend1), 15);
        chk("sat16_ovf1", 32'(Ovf1), 1);
      end
    end
    Req1 = 1'b0; OvfClr = 1'b1;
    tick();
    OvfClr = 1'b0;
    chk("clr_ovf1", 32'(Ovf1), 0);
    chk("clr_pend1", 32'(Pend1), 15);
    for (int i = 0; i < 15; i++) push(1'b1);
    Hold = 1'b0;
    repeat (15) tick();
    chk("drain1_pend1", 32'(Pend1), 0);
    tick();
    chk("drain1_idle", 32'(Idle), 1);

    // Full channel 0 with a request and a grant on every edge.
    Hold = 1'b1; Req0 = 1'b1;
    repeat (15) tick();
    chk("full0_pend0", 32'(Pend0), 15);
    Hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0);
      tick();
      chk("simul_pend0", 32'(Pend0), 15);
      chk("simul_ovf0", 32'(Ovf0), 0);
      chk("simul_en", 32'(En), 1);
    end
    // Drop coinciding with OvfClr: the set wins.
    Hold = 1'b1; OvfClr = 1'b1;
    tick();
    OvfClr = 1'b0; Req0 = 1'b0;
    chk("dropclr_ovf0", 32'(Ovf0), 1);
    chk("dropclr_pend0", 32'(Pend0), 15);
    chk("dropclr_en", 32'(En), 0);

    // Build Pend0=4, Pend1=7 with an issue in flight, then reset.
    for (int i = 0; i < 11; i++) push(1'b0);
    Hold = 1'b0;
    repeat (11) tick();
    Hold = 1'b1; Req1 = 1'b1;
    repeat (8) tick();
    Req1 = 1'b0; Hold = 1'b0;
    push(1'b1);
    tick();
    chk("mid_pend0", 32'(Pend0), 4);
    chk("mid_pend1", 32'(Pend1), 7);
    chk("mid_en", 32'(En), 1);
    chk("mid_ovf0", 32'(Ovf0), 1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    chk("midrst_en", 32'(En), 0);
    chk("midrst_pend", 32'({Pend1, Pend0}), 0);
    chk("midrst_ovf", 32'({Ovf1, Ovf0}), 0);

    // Tie after reset goes to channel 0 first.
    Req0 = 1'b1; Req1 = 1'b1;
    tick();
    Req0 = 1'b0; Req1 = 1'b0;
    push(1'b0); push(1'b1);
    tick();
    chk("tie_pend1", 32'(Pend1), 1);
    tick();
    tick();
    chk("tie_idle", 32'(Idle), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin issue scheduler in front of the dual event counter (channel 0 = direct count path, channel 1 = prescaled count path). Two independent event sources post increment requests. The block queues each source's requests in a saturating pending counter, then issues at most one increment per cycle downstream as a registered `En`/`Slt` pair, alternating fairly when both channels are pending. It also reports queue depth, sticky overflow and idle status to the control/status logic.

## Interface
Parameters:
- `CREDIT_W`, default 4: width of each pending counter. Maximum queued requests per channel is `2^CREDIT_W-1`.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-low reset. Sampled on `Clk` rising edge; 0 = reset.
- `Req0`  in  1  one increment request for channel 0 per cycle when high.
- `Req1`  in  1  one increment request for channel 1 per cycle when high.
- `Hold`  in  1  when high, no new issue is granted. Queuing continues.
- `OvfClr`  in  1  clears both sticky overflow flags.
- `En`  out  1  registered; high for exactly one cycle per issued increment.
- `Slt`  out  1  registered; channel of the current issue (0/1). Holds its last value while `En`=0.
- `Pend0`  out  CREDIT_W  channel 0 pending count (registered).
- `Pend1`  out  CREDIT_W  channel 1 pending count (registered).
- `Ovf0`  out  1  sticky: a channel 0 request was dropped.
- `Ovf1`  out  1  sticky: a channel 1 request was dropped.
- `Idle`  out  1  combinational: `Pend0`==0 && `Pend1`==0 && `En`==0.

## Operation
- Reset (`Reset`=0 at an edge):
  - `En`=0, `Slt`=0, `Pend0`=`Pend1`=0, `Ovf0`=`Ovf1`=0.
  - Last-served pointer `last`=1, so channel 0 wins the first tie.
  - `Reset` overrides every other input. Issues in flight and queued requests are discarded.
- Grant, evaluated each edge from the registered `Pend*`, `last` and the current `Hold`:
  - `Hold`=1, or both pending counts 0: no grant.
  - Exactly one pending count nonzero: grant that channel.
  - Both nonzero: grant the channel != `last`.
  - On a grant: `En`<=1, `Slt`<=channel, `last`<=channel. Otherwise `En`<=0; `Slt` and `last` are unchanged.
- Pending update, per channel i: next = `Pend_i` + `Req_i` - `grant_i`, with these rules:
  - Request and grant in the same edge: net zero change.
  - `Pend_i` at max, `Req_i`=1, no grant: count stays at max, the request is dropped, `Ovf_i`<=1.
  - Underflow cannot occur, because a grant requires a nonzero count.
- Overflow flags: `OvfClr`=1 clears both flags. If a drop happens in the same edge as `OvfClr`, the set wins (flag = 1).
- FSM: none beyond the `last` pointer. The block is fully pipelined and issues up to one increment per cycle.

## Timing
- Latency: `Req_i` sampled at edge k increments `Pend_i` after edge k. The earliest issue is `En`=1 after edge k+1, i.e. 2 edges from request to `En`.
- Throughput: 1 issue per cycle sustained. With both channels backlogged, `Slt` alternates 0,1,0,1.
- `Hold` is sampled at the edge:
  - `Hold` high at edge k gives `En`=0 after edge k.
  - Deasserting `Hold` resumes issue on the next edge, with no lost or duplicated grant.
- `Pend*`, `Ovf*`, `En`, `Slt` change only on edges. `Idle` follows the registers combinationally.
- A request arriving exactly at the saturation edge while its channel is also granted is accepted, not dropped.

## Test plan
- Reset:
  - Drive `Reset`=0 with `Req0`=`Req1`=1 and `Hold`=0 for 3 cycles, then release.
  - Required: all outputs 0 and `Idle`=1 during reset.
  - Required: first grant after release is channel 0.
- Single request:
  - `Req0` pulse at edge 5.
  - Required: `Pend0`=1 after edge 5; `En`=1, `Slt`=0 after edge 6; `Pend0`=0 and `Idle`=1 after edge 7.
- Round-robin:
  - `Hold`=1, pulse `Req0` 3 times and `Req1` 2 times, then drop `Hold`.
  - Required `Slt` sequence with `En`=1: 0,1,0,1,0. Then `En`=0 and `Pend0`=`Pend1`=0.
- Saturation, with `CREDIT_W`=4:
  - `Hold`=1, `Req1`=1 for 17 cycles.
  - Required: `Pend1`=15 and `Ovf1`=1 after the 16th request.
  - Pulse `OvfClr`: required `Ovf1`=0 and `Pend1` still 15.
- Simultaneous events:
  - `Pend0`=15 with `Hold`=0 and `Req0`=1 continuously.
  - Required: `Pend0` stays 15, `Ovf0` stays 0, `En`=1 every cycle.
  - Drop and clear in the same edge: `OvfClr`=1 at the same edge a request is dropped gives `Ovf0`=1.
- Reset mid-operation:
  - Assert `Reset`=0 for one edge while `Pend0`=4, `Pend1`=7 and `En`=1.
  - Required: next cycle `En`=0, both pending counts 0, `Ovf*`=0.
  - Required: a subsequent tie grants channel 0 first.
